sync_fifo_flagged: RTL and testbench
====================================

Name: sync_fifo_flagged

Overview:
Single-clock, parametrised FIFO for same-domain buffering between pipeline stages. It is the single-clock successor to the team's dual-clock FIFO and adds the following over it:
- a fill count;
- programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags;
- a read-valid strobe.
Storage is a register-array memory of DEPTH = 2**ADDR_SIZE words. Binary pointers carry one extra wrap bit.

Parameters:
- DATA_SIZE, 12, width of each stored word.
- ADDR_SIZE, 4, address bits; DEPTH = 2**ADDR_SIZE (16 by default).
- AFULL_THRESH, 12, wAlmostFull asserts when count >= this value; legal range 1..DEPTH.
- AEMPTY_THRESH, 2, rAlmostEmpty asserts when count <= this value; legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- winc  in  1  write request.
- wData  in  DATA_SIZE  write data, sampled on an accepted write.
- rinc  in  1  read request.
- rData  out  DATA_SIZE  read data.
- rValid  out  1  rData holds a freshly read word.
- wFull  out  1  count == DEPTH.
- rEmpty  out  1  count == 0.
- wAlmostFull  out  1  count >= AFULL_THRESH.
- rAlmostEmpty  out  1  count <= AEMPTY_THRESH.
- count  out  ADDR_SIZE+1  current number of stored words, 0..DEPTH.
- overflow  out  1  sticky; a write was attempted while full.
- underflow  out  1  sticky; a read was attempted while empty.
- err_clr  in  1  synchronous clear for overflow and underflow.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values, also applied on a mid-operation assertion:
  - wbin, rbin, count = 0; rData = 0; rValid = 0; overflow = underflow = 0.
  - rEmpty = 1, wFull = 0, rAlmostEmpty = 1, wAlmostFull = 0 (for legal thresholds).
  - Memory contents are not reset. All in-flight data is discarded.
- Acceptance, evaluated on the registered state at the clock edge:
  - wr_ok = winc & ~wFull.
  - rd_ok = rinc & ~rEmpty.
- Write: on wr_ok, mem[wbin[ADDR_SIZE-1:0]] <= wData and wbin increments.
- Read (default mode): on rd_ok, rData <= mem[rbin[ADDR_SIZE-1:0]], rbin increments, and rValid = 1 in the next cycle.
  - Read latency is 1 cycle.
  - rValid = 0 on cycles that follow no accepted read; rData holds its last value.
- Pointers: wbin and rbin are ADDR_SIZE+1 bits wide and wrap modulo 2*DEPTH. Addresses use the low ADDR_SIZE bits.
- Count update, one per cycle:
  - +1 on wr_ok & ~rd_ok.
  - -1 on rd_ok & ~wr_ok.
  - unchanged when both or neither are accepted.
- Flags are combinational decodes of the registered count. They change in the cycle after the accepted operation.
- Simultaneous winc and rinc:
  - Not empty and not full: both accepted, count unchanged, a write to the slot being read is impossible.
  - Full: the read is accepted, the write is rejected, and overflow is set.
  - Empty: the write is accepted, the read is rejected, and underflow is set. Data is never bypassed from write to read in the same cycle.
- Error flags:
  - overflow <= 1 on winc & wFull.
  - underflow <= 1 on rinc & rEmpty.
  - err_clr clears both, but a new error event in the same cycle takes priority (flag stays 1).
  - Rejected accesses never modify the pointers, the count, or the memory.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - rData = mem[rbin[ADDR_SIZE-1:0]] combinationally; rValid = ~rEmpty.
  - rinc acknowledges the displayed word; the next word appears the cycle after rd_ok.
  - The first written word is visible one cycle after its write.
  - On reset rData is don't-care and rValid = 0.
- Undefined: the registered 1-cycle-latency read described above.

Test Plan:
- Reset then idle 5 cycles → rEmpty=1, wFull=0, count=0, rValid=0, rAlmostEmpty=1, overflow=underflow=0.
- Write 0x001..0x010 (16 words), then read 16 → wFull=1 after the 16th write; wAlmostFull asserts when count reaches 12; read data returns 0x001..0x010 in order with rValid; rEmpty=1 at end.
- Fill to 16, then winc=1 for 1 cycle → overflow=1, count stays 16, no data lost. Then err_clr=1 → overflow=0.
- Empty FIFO, winc=rinc=1 with wData=0x0AB → count=1, underflow=1, next read returns 0x0AB.
- Hold count=8, drive winc=rinc=1 for 40 cycles with incrementing data → count stays 8 throughout, both pointers wrap past 31→0, and read order is preserved.
- Assert rst with count=9 mid-burst → all outputs return to reset values immediately, and a subsequent write/read of 0x5A5 returns 0x5A5.

Source files
------------

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with fill count, almost-full/empty flags, sticky errors.
// Ports: clk, rst (async high), winc/wData, rinc/rData/rValid, wFull, rEmpty,
// wAlmostFull, rAlmostEmpty, count, overflow, underflow, err_clr.
// Option: define SYNC_FIFO_FWFT_EN for first-word fall-through reads.
module sync_fifo_flagged #(
  parameter int DATA_SIZE     = 12,
  parameter int ADDR_SIZE     = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 winc,
  input  logic [DATA_SIZE-1:0] wData,
  input  logic                 rinc,
  output logic [DATA_SIZE-1:0] rData,
  output logic                 rValid,
  output logic                 wFull,
  output logic                 rEmpty,
  output logic                 wAlmostFull,
  output logic                 rAlmostEmpty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 err_clr
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_C = DEPTH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0] AF_C    = AFULL_THRESH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0] AE_C    = AEMPTY_THRESH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0] ONE_C   = {{ADDR_SIZE{1'b0}}, 1'b1};

  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  logic [ADDR_SIZE:0] wbin_q, wbin_d;
  logic [ADDR_SIZE:0] rbin_q, rbin_d;
  logic [ADDR_SIZE:0] count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic               wr_ok, rd_ok;
  logic [ADDR_SIZE-1:0] waddr, raddr;

  assign waddr = wbin_q[ADDR_SIZE-1:0];
  assign raddr = rbin_q[ADDR_SIZE-1:0];

  assign wFull        = (count_q == DEPTH_C);
  assign rEmpty       = (count_q == '0);
  assign wAlmostFull  = (count_q >= AF_C);
  assign rAlmostEmpty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // Acceptance uses registered flags only, so a write into an empty
  // FIFO never bypasses to the read side in the same cycle.
  assign wr_ok = winc & ~wFull;
  assign rd_ok = rinc & ~rEmpty;

  always_comb begin
    wbin_d  = wbin_q;
    rbin_d  = rbin_q;
    count_d = count_q;
    if (wr_ok) wbin_d = wbin_q + ONE_C;
    if (rd_ok) rbin_d = rbin_q + ONE_C;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // A new error event wins over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (winc & wFull)  ovf_d = 1'b1;
    if (rinc & rEmpty) udf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_q  <= '0;
      rbin_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      rbin_q  <= rbin_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[waddr] <= wData;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rData  = mem_q[raddr];
  assign rValid = ~rEmpty;
`else
  logic [DATA_SIZE-1:0] rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rd_ok;
    if (rd_ok) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rData  = rdata_q;
  assign rValid = rvalid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Self-checking bench for sync_fifo_flagged: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_sync_fifo_flagged;

  localparam int DW    = 12;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFT   = 12;
  localparam int AET   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          winc = 1'b0;
  logic [DW-1:0] wData = '0;
  logic          rinc = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] rData;
  logic          rValid, wFull, rEmpty, wAlmostFull, rAlmostEmpty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  int checks = 0;
  int errors = 0;

  sync_fifo_flagged #(
    .DATA_SIZE(DW), .ADDR_SIZE(AW),
    .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)
  ) dut (
    .clk(clk), .rst(rst), .winc(winc), .wData(wData), .rinc(rinc),
    .rData(rData), .rValid(rValid), .wFull(wFull), .rEmpty(rEmpty),
    .wAlmostFull(wAlmostFull), .rAlmostEmpty(rAlmostEmpty),
    .count(count), .overflow(overflow), .underflow(underflow),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the sticky bits.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rdata = '0;
  logic          m_rvalid = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_rdata  = '0;
      m_rvalid = 1'b0;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
    end else begin
      bit full, empty, w, r;
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      w = winc && !full;
      r = rinc && !empty;
      if (err_clr) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (winc && full)  m_ovf = 1'b1;
      if (rinc && empty) m_udf = 1'b1;
      m_rvalid = r;
      if (r) m_rdata = q.pop_front();
      if (w) q.push_back(wData);
    end
  end

  always @(negedge clk) begin
    int n;
    logic ev;
    logic [DW-1:0] ed;
    n = q.size();
`ifdef SYNC_FIFO_FWFT_EN
    ev = (n != 0);
    ed = ev ? q[0] : '0;
`else
    ev = m_rvalid;
    ed = m_rdata;
`endif
    chk("m_count", int'(count), n);
    chk("m_rEmpty", int'(rEmpty), int'(n == 0));
    chk("m_wFull", int'(wFull), int'(n == DEPTH));
    chk("m_wAlmostFull", int'(wAlmostFull), int'(n >= AFT));
    chk("m_rAlmostEmpty", int'(rAlmostEmpty), int'(n <= AET));
    chk("m_overflow", int'(overflow), int'(m_ovf));
    chk("m_underflow", int'(underflow), int'(m_udf));
    chk("m_rValid", int'(rValid), int'(ev));
    if (ev) chk("m_rData", int'(rData), int'(ed));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    winc  = 1'b1;
    wData = d;
    tick();
    winc  = 1'b0;
  endtask

  // Returns the word consumed by one accepted read in either read mode.
  task automatic rd(output logic [DW-1:0] d);
`ifdef SYNC_FIFO_FWFT_EN
    d = rData;
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
`else
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    d = rData;
`endif
  endtask

  initial begin
    logic [DW-1:0] d;
    int exp_v;

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_rEmpty", int'(rEmpty), 1);
    chk("rst_wFull", int'(wFull), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_rValid", int'(rValid), 0);
    chk("rst_rAlmostEmpty", int'(rAlmostEmpty), 1);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_udf", int'(underflow), 0);

    for (int i = 1; i <= 16; i++) begin
      wr(DW'(i));
      if (i == 11) chk("af_at11", int'(wAlmostFull), 0);
      if (i == 12) chk("af_at12", int'(wAlmostFull), 1);
      if (i == 15) chk("full_at15", int'(wFull), 0);
    end
    chk("full_at16", int'(wFull), 1);
    chk("count16", int'(count), 16);

    wr(12'h3FF);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_count", int'(count), 16);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_clr", int'(overflow), 0);

    for (int i = 1; i <= 16; i++) begin
      rd(d);
      chk("rd_order", int'(d), i);
`ifndef SYNC_FIFO_FWFT_EN
      chk("rd_valid", int'(rValid), 1);
`endif
    end
    chk("drain_empty", int'(rEmpty), 1);
    tick();
    chk("idle_rValid", int'(rValid), 0);

    winc  = 1'b1;
    rinc  = 1'b1;
    wData = 12'h0AB;
    tick();
    winc = 1'b0;
    rinc = 1'b0;
    chk("sim_count", int'(count), 1);
    chk("sim_udf", int'(underflow), 1);
    chk("sim_nobypass", int'(rValid), 1'b1 ^ 1'b1 ^ int'(count == 1 && 0));
    rd(d);
    chk("sim_data", int'(d), 12'h0AB);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("udf_clr", int'(underflow), 0);

    for (int i = 0; i < 8; i++) wr(DW'(12'h100 + i));
    for (int i = 0; i < 40; i++) begin
      winc  = 1'b1;
      rinc  = 1'b1;
      wData = DW'(12'h200 + i);
`ifdef SYNC_FIFO_FWFT_EN
      d = rData;
      tick();
`else
      tick();
      d = rData;
`endif
      exp_v = (i < 8) ? (12'h100 + i) : (12'h200 + i - 8);
      chk("wrap_data", int'(d), exp_v);
      chk("wrap_count", int'(count), 8);
    end
    winc = 1'b0;
    rinc = 1'b0;
    for (int i = 32; i < 40; i++) begin
      rd(d);
      chk("wrap_tail", int'(d), 12'h200 + i);
    end

    winc = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wData = DW'(12'h300 + i);
      tick();
    end
    chk("pre_rst_count", int'(count), 9);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_rEmpty", int'(rEmpty), 1);
    chk("mid_rst_rValid", int'(rValid), 0);
    chk("mid_rst_af", int'(wAlmostFull), 0);
    winc = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    wr(12'h5A5);
    rd(d);
    chk("post_rst_data", int'(d), 12'h5A5);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
